// File: rtl/fifo_read_engine_pkg.sv
// Shared definitions for the FIFO read engine.
// Contents:
//   DEPTH_DEF / WIDTH_DEF - default FIFO capacity and word width
//   LEVEL_W               - occupancy counter width for the default depth (0..DEPTH)
//   state_e               - read-engine FSM states
//   level_w()             - occupancy counter width for an arbitrary depth
package fifo_read_engine_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 8;
  localparam int LEVEL_W   = $clog2(DEPTH_DEF) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_read_engine_if.sv
// Valid/ready stream carrying words from the read engine to its consumer.
// Signals:
//   m_data  - stream word (engine -> consumer)
//   m_valid - m_data holds a word (engine -> consumer)
//   m_ready - consumer accepts the word this cycle (consumer -> engine)
// Modports: master (engine side), slave (consumer side).
interface fifo_read_engine_if
  import fifo_read_engine_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/fifo_read_engine_skid_buf.sv
// Two-entry in-order skid buffer holding words returned by the FIFO.
// Ports:
//   clock, reset - clock and synchronous active-high reset (control only)
//   push_i/din_i - capture din_i this edge
//   pop_i        - oldest entry consumed this edge (only asserted while valid)
//   dout_o       - oldest entry, 0 when empty
//   valid_o      - buffer non-empty
//   count_o      - number of stored entries (0..2)
module read_skid_buf
  import fifo_read_engine_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_i  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; an empty buffer presents zero instead.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign valid_o = (count_q != 2'd0);
  assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fifo_read_engine.sv
// Read engine draining an external FIFO into a valid/ready stream.
// Tracks FIFO occupancy by snooping the writer strobe and counting its own
// reads, keeps at most two words buffered-or-in-flight, and latches sticky
// under/overflow errors. An underflow halts new reads until err_clear.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   fifo_write_n          - snooped writer strobe (active-low)
//   fifo_read_n           - FIFO read strobe (active-low, combinational)
//   fifo_data_out         - FIFO read data, valid the cycle after a read edge
//   fifo_under_flow/over  - FIFO status flags
//   m_if                  - output stream (master modport)
//   level                 - tracked FIFO occupancy 0..DEPTH
//   err_under, err_over   - sticky error flags; err_clear clears both
module fifo_read_engine
  import fifo_read_engine_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fifo_write_n,
  output logic                     fifo_read_n,
  input  logic [WIDTH-1:0]         fifo_data_out,
  input  logic                     fifo_under_flow,
  input  logic                     fifo_over_flow,
  fifo_read_engine_if.master       m_if,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_under,
  output logic                     err_over,
  input  logic                     err_clear
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_e          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic            in_flight_q;
  logic            err_under_q, err_under_d;
  logic            err_over_q, err_over_d;
  logic [1:0]      buf_count;
  logic [1:0]      buf_count_d;
  logic [2:0]      demand;
  logic            pop, rd_issue, wr_seen, busy_d;

  assign pop     = m_if.m_valid & m_if.m_ready;
  assign wr_seen = ~fifo_write_n;

  // Words already committed downstream after this cycle's pop; a new read is
  // only issued while fewer than two are committed, so the skid buffer can
  // never overflow even when the consumer stalls.
  assign demand = {1'b0, buf_count} + {2'b00, in_flight_q} - {2'b00, pop};

  // Counter and error flag next-state.
  always_comb begin
    level_d = level_q;
    if (wr_seen && !rd_issue && (level_q < DEPTH_L)) level_d = level_q + 1'b1;
    else if (!wr_seen && rd_issue)                   level_d = level_q - 1'b1;

    err_under_d = err_under_q | fifo_under_flow | (rd_issue & (level_q == '0));
    err_over_d  = err_over_q  | fifo_over_flow;
    if (err_clear) begin
      err_under_d = 1'b0;
      err_over_d  = 1'b0;
    end
  end

  // FSM next-state and read strobe.
  always_comb begin
    rd_issue    = 1'b0;
    fifo_read_n = 1'b1;
    state_d     = state_q;
    buf_count_d = buf_count;
    busy_d      = 1'b0;

    if ((state_q != ST_ERROR) && (level_q != '0) && (demand < 3'd2)) rd_issue = 1'b1;
    fifo_read_n = ~rd_issue;

    buf_count_d = buf_count + {1'b0, in_flight_q} - {1'b0, pop};
    busy_d      = (buf_count_d != 2'd0) | rd_issue;

    if (err_under_d)  state_d = ST_ERROR;
    else if (busy_d)  state_d = ST_ACTIVE;
    else              state_d = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      in_flight_q <= 1'b0;
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      in_flight_q <= rd_issue;
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
    end
  end

  // Returned data is captured on the edge after the read was sampled.
  read_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .push_i  (in_flight_q),
    .din_i   (fifo_data_out),
    .pop_i   (pop),
    .dout_o  (m_if.m_data),
    .valid_o (m_if.m_valid),
    .count_o (buf_count)
  );

  assign level     = level_q;
  assign err_under = err_under_q;
  assign err_over  = err_over_q;

endmodule

// File: tb/tb_fifo_read_engine.sv
module tb_fifo_read_engine;
  import fifo_read_engine_pkg::*;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             fifo_write_n = 1'b1;
  logic             fifo_read_n;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_under_flow = 1'b0;
  logic             fifo_over_flow;
  logic [4:0]       level;
  logic             err_under, err_over;
  logic             err_clear = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_cnt = 0;
  logic [WIDTH-1:0] got_q[$];
  int               got_t[$];
  logic [WIDTH-1:0] mq[$];

  fifo_read_engine_if #(.WIDTH(WIDTH)) bus ();

  fifo_read_engine #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock           (clock),
    .reset           (reset),
    .fifo_write_n    (fifo_write_n),
    .fifo_read_n     (fifo_read_n),
    .fifo_data_out   (fifo_data_out),
    .fifo_under_flow (fifo_under_flow),
    .fifo_over_flow  (fifo_over_flow),
    .m_if            (bus),
    .level           (level),
    .err_under       (err_under),
    .err_over        (err_over),
    .err_clear       (err_clear)
  );

  always #5 clock = ~clock;

  // Behavioural FIFO: a queue of capacity DEPTH, read data one cycle late.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      fifo_data_out  <= '0;
      fifo_over_flow <= 1'b0;
    end else begin
      fifo_over_flow <= 1'b0;
      if (!fifo_read_n && mq.size() > 0) fifo_data_out <= mq.pop_front();
      if (!fifo_write_n) begin
        if (mq.size() < DEPTH) mq.push_back(wr_data);
        else fifo_over_flow <= 1'b1;
      end
    end
  end

  // Stream monitor: records delivered words, delivery cycles and issued reads.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!reset) begin
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back(bus.m_data);
        got_t.push_back(cyc);
      end
      if (!fifo_read_n) rd_cnt = rd_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    fifo_write_n = 1'b1;
    fifo_under_flow = 1'b0;
    err_clear = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    got_q.delete();
    got_t.delete();
    rd_cnt = 0;
  endtask

  task automatic wr_word(input logic [WIDTH-1:0] d);
    wr_data = d;
    fifo_write_n = 1'b0;
    @(negedge clock);
    fifo_write_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    total++; if (bus.m_data !== 8'd0) begin bad++; $display("FAIL reset_m_data: got %0d want 0", bus.m_data); end
    total++; if (fifo_read_n !== 1'b1) begin bad++; $display("FAIL reset_read_n: got %b want 1", fifo_read_n); end
    total++; if (err_under !== 1'b0) begin bad++; $display("FAIL reset_err_under: got %b want 0", err_under); end
    total++; if (err_over !== 1'b0) begin bad++; $display("FAIL reset_err_over: got %b want 0", err_over); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    wr_word(8'd5);
    total++; if (fifo_read_n !== 1'b0) begin bad++; $display("FAIL single_read_n: got %b want 0", fifo_read_n); end
    total++; if (level !== 5'd1) begin bad++; $display("FAIL single_level: got %0d want 1", level); end
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_valid_e1: got %b want 0", bus.m_valid); end
    @(negedge clock);
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_valid_e2: got %b want 0", bus.m_valid); end
    @(negedge clock);
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL single_valid_e3: got %b want 1", bus.m_valid); end
    total++; if (bus.m_data !== 8'd5) begin bad++; $display("FAIL single_data: got %0d want 5", bus.m_data); end
    bus.m_ready = 1'b1;
    @(negedge clock);
    bus.m_ready = 1'b0;
    total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL single_drained: got %b want 0", bus.m_valid); end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] e;
    logic [4:0] el;
    do_reset();
    for (int i = 0; i < DEPTH; i++) wr_word(8'(DEPTH - i));
    repeat (4) @(negedge clock);
    el = 5'(DEPTH - 2);
    total++; if (rd_cnt != 2) begin bad++; $display("FAIL fill_reads: got %0d want 2", rd_cnt); end
    total++; if (level !== el) begin bad++; $display("FAIL fill_level: got %0d want %0d", level, el); end
    total++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'd16) begin bad++; $display("FAIL fill_head: got v=%b d=%0d want v=1 d=16", bus.m_valid, bus.m_data); end
    repeat (3) @(negedge clock);
    total++; if (bus.m_data !== 8'd16 || got_q.size() != 0) begin bad++; $display("FAIL fill_hold: got d=%0d n=%0d want d=16 n=0", bus.m_data, got_q.size()); end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 60 && got_q.size() < DEPTH; k++) @(negedge clock);
    total++; if (got_q.size() != DEPTH) begin bad++; $display("FAIL fill_count: got %0d want %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < got_q.size(); i++) begin
      e = 8'(DEPTH - i);
      total++; if (got_q[i] !== e) begin bad++; $display("FAIL fill_order[%0d]: got %0d want %0d", i, got_q[i], e); end
    end
    if (got_t.size() == DEPTH) begin
      total++; if (got_t[DEPTH-1] - got_t[0] != DEPTH - 1) begin bad++; $display("FAIL fill_rate: got span %0d want %0d", got_t[DEPTH-1] - got_t[0], DEPTH - 1); end
    end
    total++; if (level !== 5'd0) begin bad++; $display("FAIL fill_level_end: got %0d want 0", level); end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [WIDTH-1:0] e;
    do_reset();
    for (int i = 0; i < DEPTH + 4; i++) wr_word(8'(100 + i));
    repeat (3) @(negedge clock);
    total++; if (level !== 5'(DEPTH)) begin bad++; $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); end
    total++; if (err_over !== 1'b1) begin bad++; $display("FAIL ovf_err_over: got %b want 1", err_over); end
    total++; if (err_under !== 1'b0) begin bad++; $display("FAIL ovf_err_under: got %b want 0", err_under); end
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    total++; if (err_over !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", err_over); end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 80 && got_q.size() < DEPTH + 2; k++) @(negedge clock);
    repeat (3) @(negedge clock);
    total++; if (got_q.size() != DEPTH + 2) begin bad++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), DEPTH + 2); end
    for (int i = 0; i < got_q.size(); i++) begin
      e = 8'(100 + i);
      total++; if (got_q[i] !== e) begin bad++; $display("FAIL ovf_order[%0d]: got %0d want %0d", i, got_q[i], e); end
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    wr_word(8'd31); wr_word(8'd32); wr_word(8'd33);
    repeat (4) @(negedge clock);
    fifo_under_flow = 1'b1;
    @(negedge clock);
    fifo_under_flow = 1'b0;
    total++; if (err_under !== 1'b1) begin bad++; $display("FAIL unf_err: got %b want 1", err_under); end
    total++; if (dut.state_q !== ST_ERROR) begin bad++; $display("FAIL unf_state: got %0d want %0d", dut.state_q, ST_ERROR); end
    bus.m_ready = 1'b1;
    repeat (6) @(negedge clock);
    total++; if (fifo_read_n !== 1'b1 || rd_cnt != 2) begin bad++; $display("FAIL unf_no_read: got rn=%b reads=%0d want rn=1 reads=2", fifo_read_n, rd_cnt); end
    total++; if (got_q.size() != 2 || level !== 5'd1) begin bad++; $display("FAIL unf_drain: got n=%0d lvl=%0d want n=2 lvl=1", got_q.size(), level); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0] !== 8'd31 || got_q[1] !== 8'd32) begin bad++; $display("FAIL unf_order: got %0d,%0d want 31,32", got_q[0], got_q[1]); end
    end
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    total++; if (err_under !== 1'b0 || err_over !== 1'b0) begin bad++; $display("FAIL unf_clear: got u=%b o=%b want 0 0", err_under, err_over); end
    total++; if (dut.state_q === ST_ERROR) begin bad++; $display("FAIL unf_state_clear: got %0d want not %0d", dut.state_q, ST_ERROR); end
    for (int k = 0; k < 10 && got_q.size() < 3; k++) @(negedge clock);
    total++; if (got_q.size() != 3 || rd_cnt != 3) begin bad++; $display("FAIL unf_resume: got n=%0d reads=%0d want n=3 reads=3", got_q.size(), rd_cnt); end
    if (got_q.size() == 3) begin
      total++; if (got_q[2] !== 8'd33) begin bad++; $display("FAIL unf_last: got %0d want 33", got_q[2]); end
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_simul();
    logic [WIDTH-1:0] exp_w [4];
    exp_w[0] = 8'd41; exp_w[1] = 8'd42; exp_w[2] = 8'd43; exp_w[3] = 8'd8;
    do_reset();
    wr_word(8'd41); wr_word(8'd42); wr_word(8'd43);
    repeat (4) @(negedge clock);
    bus.m_ready = 1'b1;
    wr_data = 8'd8;
    fifo_write_n = 1'b0;
    #1;
    total++; if (fifo_read_n !== 1'b0 || level !== 5'd1) begin bad++; $display("FAIL simul_pre: got rn=%b lvl=%0d want rn=0 lvl=1", fifo_read_n, level); end
    @(negedge clock);
    fifo_write_n = 1'b1;
    total++; if (level !== 5'd1) begin bad++; $display("FAIL simul_level: got %0d want 1", level); end
    for (int k = 0; k < 12 && got_q.size() < 4; k++) @(negedge clock);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL simul_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      total++; if (got_q[i] !== exp_w[i]) begin bad++; $display("FAIL simul_order[%0d]: got %0d want %0d", i, got_q[i], exp_w[i]); end
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_word(8'd51); wr_word(8'd52); wr_word(8'd53);
    repeat (4) @(negedge clock);
    total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL rstmid_setup: got %b want 1", bus.m_valid); end
    reset = 1'b1;
    @(negedge clock);
    total++; if (bus.m_valid !== 1'b0 || level !== 5'd0 || fifo_read_n !== 1'b1) begin bad++; $display("FAIL rstmid_state: got v=%b lvl=%0d rn=%b want 0 0 1", bus.m_valid, level, fifo_read_n); end
    reset = 1'b0;
    got_q.delete();
    bus.m_ready = 1'b1;
    repeat (5) @(negedge clock);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL rstmid_discard: got %0d words want 0", got_q.size()); end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] d, prev_d;
    logic [4:0] el;
    logic prev_v, prev_r;
    do_reset();
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      el = 5'(mq.size());
      total++; if (level !== el) begin bad++; $display("FAIL rand_level@%0d: got %0d want %0d", i, level, el); end
      if (prev_v && !prev_r) begin
        total++; if (bus.m_valid !== 1'b1 || bus.m_data !== prev_d) begin bad++; $display("FAIL rand_hold@%0d: got v=%b d=%0d want v=1 d=%0d", i, bus.m_valid, bus.m_data, prev_d); end
      end
      prev_v = bus.m_valid;
      prev_d = bus.m_data;
      if (i < 200) bus.m_ready = ($urandom_range(0, 3) == 0);
      else         bus.m_ready = ($urandom_range(0, 3) != 0);
      prev_r = bus.m_ready;
      if (($urandom_range(0, 1) == 1) && (mq.size() < DEPTH - 1)) begin
        d = 8'($urandom);
        wr_data = d;
        fifo_write_n = 1'b0;
        exp_q.push_back(d);
      end else begin
        fifo_write_n = 1'b1;
      end
    end
    @(negedge clock);
    fifo_write_n = 1'b1;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 100 && got_q.size() < exp_q.size(); k++) @(negedge clock);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_order[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
    end
    total++; if (err_under !== 1'b0 || err_over !== 1'b0) begin bad++; $display("FAIL rand_errs: got u=%b o=%b want 0 0", err_under, err_over); end
    bus.m_ready = 1'b0;
  endtask

  initial begin
    bus.m_ready = 1'b0;
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_simul();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
